// File: rtl/adpcm_decoder.sv
// IMA ADPCM decoder: 4-bit codes in, signed 16-bit PCM out.
// Bit-serial difference build over three cycles, then predictor/index update.
module adpcm_decoder #(
  parameter int                 INIT_INDEX = 0,
  parameter logic signed [15:0] INIT_PRED  = 16'sd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        block_enable,
  input  logic        code_valid,
  input  logic [3:0]  code_in,
  output logic        code_ready,
  output logic        pcm_valid,
  output logic [15:0] pcm_out,
  input  logic        pcm_ready
);

  typedef enum logic [2:0] {
    IDLE, CALC1, CALC2, CALC3, UPD, OUT
  } state_t;

  localparam logic [14:0] STEP_TBL [89] = '{
    15'd7, 15'd8, 15'd9, 15'd10, 15'd11, 15'd12,
    15'd13, 15'd14, 15'd16, 15'd17, 15'd19, 15'd21,
    15'd23, 15'd25, 15'd28, 15'd31, 15'd34, 15'd37,
    15'd41, 15'd45, 15'd50, 15'd55, 15'd60, 15'd66,
    15'd73, 15'd80, 15'd88, 15'd97, 15'd107, 15'd118,
    15'd130, 15'd143, 15'd157, 15'd173, 15'd190,
    15'd209, 15'd230, 15'd253, 15'd279, 15'd307,
    15'd337, 15'd371, 15'd408, 15'd449, 15'd494,
    15'd544, 15'd598, 15'd658, 15'd724, 15'd796,
    15'd876, 15'd963, 15'd1060, 15'd1166, 15'd1282,
    15'd1411, 15'd1552, 15'd1707, 15'd1878, 15'd2066,
    15'd2272, 15'd2499, 15'd2749, 15'd3024, 15'd3327,
    15'd3660, 15'd4026, 15'd4428, 15'd4871, 15'd5358,
    15'd5894, 15'd6484, 15'd7132, 15'd7845, 15'd8630,
    15'd9493, 15'd10442, 15'd11487, 15'd12635,
    15'd13899, 15'd15289, 15'd16818, 15'd18500,
    15'd20350, 15'd22385, 15'd24623, 15'd27086,
    15'd29794, 15'd32767
  };

  state_t             state, state_nx;
  logic [3:0]         code_q;
  logic [16:0]        diff;
  logic signed [15:0] pred;
  logic [6:0]         index;
  logic [14:0]        step;
  logic signed [17:0] sum;
  logic signed [15:0] pred_sat;
  logic signed [7:0]  adj;
  logic signed [7:0]  idx_sum;
  logic [6:0]         index_nx;
  logic               accept;

  assign step       = STEP_TBL[index];
  assign code_ready = rst_n && block_enable && (state == IDLE);
  assign pcm_valid  = (state == OUT);
  assign pcm_out    = pred;
  assign accept     = code_ready && code_valid;

  always_comb begin
    sum = code_q[3]
        ? {{2{pred[15]}}, pred} - $signed({1'b0, diff})
        : {{2{pred[15]}}, pred} + $signed({1'b0, diff});
    if (sum > 18'sd32767)
      pred_sat = 16'sh7FFF;
    else if (sum < -18'sd32768)
      pred_sat = 16'sh8000;
    else
      pred_sat = sum[15:0];
  end

  // codes 0..3 step down by one; 4..7 step up by 2,4,6,8
  always_comb begin
    adj = code_q[2]
        ? $signed({5'd0, code_q[1:0], 1'b0}) + 8'sd2
        : -8'sd1;
    idx_sum = $signed({1'b0, index}) + adj;
    if (idx_sum < 8'sd0)
      index_nx = 7'd0;
    else if (idx_sum > 8'sd88)
      index_nx = 7'd88;
    else
      index_nx = idx_sum[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!block_enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nx = CALC1;
        CALC1:   state_nx = CALC2;
        CALC2:   state_nx = CALC3;
        CALC3:   state_nx = UPD;
        UPD:     state_nx = OUT;
        OUT:     if (pcm_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= 4'd0;
      diff   <= 17'd0;
      pred   <= INIT_PRED;
      index  <= 7'(INIT_INDEX);
    end else if (!block_enable) begin
      code_q <= 4'd0;
      diff   <= 17'd0;
      pred   <= INIT_PRED;
      index  <= 7'(INIT_INDEX);
    end else begin
      unique case (1'b1)
        accept: begin
          code_q <= code_in;
          diff   <= 17'(step >> 3);
        end
        (state == CALC1) && code_q[2]:
          diff <= diff + 17'(step);
        (state == CALC2) && code_q[1]:
          diff <= diff + 17'(step >> 1);
        (state == CALC3) && code_q[0]:
          diff <= diff + 17'(step >> 2);
        (state == UPD): begin
          pred  <= pred_sat;
          index <= index_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adpcm_decoder.sv
// Randomized bench for adpcm_decoder against an arithmetic IMA model.
// Covers reset, latency, saturation, clamping, stall and clear.
module tb_adpcm_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        block_enable = 1'b0;
  logic        code_valid = 1'b0;
  logic [3:0]  code_in = 4'd0;
  logic        code_ready;
  logic        pcm_valid;
  logic [15:0] pcm_out;
  logic        pcm_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int m_pred = 0;
  int m_idx = 0;

  int step_tbl [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23,
    25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73,
    80, 88, 97, 107, 118, 130, 143, 157, 173, 190,
    209, 230, 253, 279, 307, 337, 371, 408, 449, 494,
    544, 598, 658, 724, 796, 876, 963, 1060, 1166,
    1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499,
    2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
    12635, 13899, 15289, 16818, 18500, 20350, 22385,
    24623, 27086, 29794, 32767
  };

  adpcm_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .block_enable (block_enable),
    .code_valid   (code_valid),
    .code_in      (code_in),
    .code_ready   (code_ready),
    .pcm_valid    (pcm_valid),
    .pcm_out      (pcm_out),
    .pcm_ready    (pcm_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pcm_s();
    return int'($signed(pcm_out));
  endfunction

  function automatic void model_reset();
    m_pred = 0;
    m_idx  = 0;
  endfunction

  function automatic void model_step(input logic [3:0] c);
    int step, diff;
    step = step_tbl[m_idx];
    diff = step / 8;
    if (c[2]) diff += step;
    if (c[1]) diff += step / 2;
    if (c[0]) diff += step / 4;
    m_pred = c[3] ? m_pred - diff : m_pred + diff;
    if (m_pred > 32767)  m_pred = 32767;
    if (m_pred < -32768) m_pred = -32768;
    m_idx += c[2] ? 2 * (int'(c[1:0]) + 1) : -1;
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 88) m_idx = 88;
  endfunction

  task automatic accept(input logic [3:0] c);
    int n = 0;
    code_in    = c;
    code_valid = 1'b1;
    while (!code_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", int'(code_ready), 1);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] c, input int hold);
    int lat = 0;
    pcm_ready = (hold == 0);
    accept(c);
    model_step(c);
    while (!pcm_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    check("pcm", pcm_s(), m_pred);
    if (hold > 0) begin
      code_valid = 1'b1;
      code_in    = 4'($urandom);
      for (int i = 0; i < hold; i++) begin
        check("stall_valid", int'(pcm_valid), 1);
        check("stall_pcm", pcm_s(), m_pred);
        check("stall_ready", int'(code_ready), 0);
        @(negedge clk);
      end
      pcm_ready = 1'b1;
      @(negedge clk);
      code_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
    check("valid_drop", int'(pcm_valid), 0);
    check("idle_ready", int'(code_ready), 1);
    check("pcm_hold", pcm_s(), m_pred);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ready", int'(code_ready), 0);
    check("rst_pcm", pcm_s(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #1;
    check("reset_ready", int'(code_ready), 0);
    check("reset_valid", int'(pcm_valid), 0);
    check("reset_pcm", pcm_s(), 0);
    block_enable = 1'b1;
    #1;
    check("reset_ready_en", int'(code_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready0", int'(code_ready), 1);
    model_reset();

    send(4'h7, 0);
    check("first_7", pcm_s(), 11);
    send(4'hF, 0);
    check("then_F", pcm_s(), -19);

    accept(4'h7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", int'(pcm_valid), 0);
    check("async_ready", int'(code_ready), 0);
    check("async_pcm", pcm_s(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    send(4'h0, 0);
    check("code0", pcm_s(), 0);
    send(4'h8, 0);
    check("code8", pcm_s(), 0);
    send(4'h7, 0);
    check("idx_clamp_low", pcm_s(), 11);

    reset_pulse();
    repeat (60) send(4'h7, 0);
    check("sat_hi", pcm_s(), 32767);
    repeat (60) send(4'hF, 0);
    check("sat_lo", pcm_s(), -32768);

    send(4'h3, 10);

    accept(4'h7);
    @(negedge clk);
    block_enable = 1'b0;
    @(negedge clk);
    check("clr_ready", int'(code_ready), 0);
    check("clr_valid", int'(pcm_valid), 0);
    check("clr_pcm", pcm_s(), 0);
    block_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("clr_no_valid", int'(pcm_valid), 0);
    end
    model_reset();
    send(4'h7, 0);
    check("clr_then_7", pcm_s(), 11);

    repeat (200) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
